// File: rtl/execute_div_pkg.sv
// Shared configuration and pack types for the divide execute unit.
// Field layouts mirror the issue, writeback and commit interfaces of the core.
package execute_div_pkg;
  localparam int XLEN                = 32;
  localparam int PHY_REG_ID_WIDTH    = 6;
  localparam int ROB_ID_WIDTH        = 5;
  localparam int CHECKPOINT_ID_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ALU, OP_BRU, OP_CSR, OP_LSU, OP_MUL, OP_DIV
  } op_t;

  typedef enum logic [2:0] {
    UNIT_ALU, UNIT_BRU, UNIT_CSR, UNIT_LSU, UNIT_MUL, UNIT_DIV
  } op_unit_t;

  typedef enum logic [1:0] {
    DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU
  } div_op_t;

  typedef enum logic [3:0] {
    EXC_INSTRUCTION_ADDRESS_MISALIGNED = 4'd0,
    EXC_INSTRUCTION_ACCESS_FAULT       = 4'd1,
    EXC_ILLEGAL_INSTRUCTION            = 4'd2,
    EXC_BREAKPOINT                     = 4'd3,
    EXC_LOAD_ADDRESS_MISALIGNED        = 4'd4,
    EXC_LOAD_ACCESS_FAULT              = 4'd5,
    EXC_STORE_ADDRESS_MISALIGNED       = 4'd6,
    EXC_STORE_ACCESS_FAULT             = 4'd7,
    EXC_ECALL_FROM_M                   = 4'd11
  } riscv_exception_t;

  typedef enum logic [1:0] {
    ARG_SRC_REG, ARG_SRC_IMM, ARG_SRC_DISABLE
  } arg_src_t;

  // Upper bits are reserved for the other units' sub-op encodings.
  typedef struct packed {
    logic [1:0] reserved;
    div_op_t    div_op;
  } sub_op_t;

  typedef struct packed {
    logic                           enable;
    logic [31:0]                    value;
    logic                           valid;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic [XLEN-1:0]                pc;
    logic [XLEN-1:0]                imm;
    logic                           has_exception;
    riscv_exception_t               exception_id;
    logic [XLEN-1:0]                exception_value;
    logic                           predicted;
    logic                           predicted_jump;
    logic [XLEN-1:0]                predicted_next_pc;
    logic                           checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
    logic [4:0]                     rs1;
    arg_src_t                       arg1_src;
    logic                           rs1_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
    logic [XLEN-1:0]                src1_value;
    logic                           src1_loaded;
    logic [4:0]                     rs2;
    arg_src_t                       arg2_src;
    logic                           rs2_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
    logic [XLEN-1:0]                src2_value;
    logic                           src2_loaded;
    logic [4:0]                     rd;
    logic                           rd_enable;
    logic                           need_rename;
    logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
    logic [11:0]                    csr;
    logic [XLEN-1:0]                lsu_addr;
    op_t                            op;
    op_unit_t                       op_unit;
    sub_op_t                        sub_op;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                           enable;
    logic [31:0]                    value;
    logic                           valid;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic [XLEN-1:0]                pc;
    logic [XLEN-1:0]                imm;
    logic                           has_exception;
    riscv_exception_t               exception_id;
    logic [XLEN-1:0]                exception_value;
    logic                           predicted;
    logic                           predicted_jump;
    logic [XLEN-1:0]                predicted_next_pc;
    logic                           checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
    logic [4:0]                     rs1;
    arg_src_t                       arg1_src;
    logic                           rs1_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
    logic [XLEN-1:0]                src1_value;
    logic                           src1_loaded;
    logic [4:0]                     rs2;
    arg_src_t                       arg2_src;
    logic                           rs2_need_map;
    logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
    logic [XLEN-1:0]                src2_value;
    logic                           src2_loaded;
    logic [4:0]                     rd;
    logic                           rd_enable;
    logic                           need_rename;
    logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
    logic [XLEN-1:0]                rd_value;
    logic [11:0]                    csr;
    logic [XLEN-1:0]                lsu_addr;
    op_t                            op;
    op_unit_t                       op_unit;
    sub_op_t                        sub_op;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                        enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [XLEN-1:0]             value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic                    enable;
    logic                    flush;
    logic [ROB_ID_WIDTH-1:0] committed_rob_id;
  } commit_feedback_pack_t;
endpackage

// File: rtl/execute_div_div_core.sv
// Combinational 32-bit RISC-V divider covering div/divu/rem/remu,
// including the architected divide-by-zero results.
module div_core
  import execute_div_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  div_op_t         div_op,
  output logic [XLEN-1:0] result
);
  logic            is_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] den;
  logic [XLEN-1:0] quo_mag;
  logic [XLEN-1:0] rem_mag;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  assign is_signed = (div_op == DIV_DIV) || (div_op == DIV_REM);
  assign is_rem    = (div_op == DIV_REM) || (div_op == DIV_REMU);
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  assign b_zero    = (b == '0);

  // One unsigned divider on magnitudes; the most-negative / -1 overflow case
  // falls out naturally (|a| wraps to 0x80000000, quotient re-negates to itself).
  assign a_mag   = a_neg ? (~a + 1'b1) : a;
  assign b_mag   = b_neg ? (~b + 1'b1) : b;
  assign den     = b_zero ? {{(XLEN-1){1'b0}}, 1'b1} : b_mag;
  assign quo_mag = a_mag / den;
  assign rem_mag = a_mag % den;
  assign quo     = (a_neg ^ b_neg) ? (~quo_mag + 1'b1) : quo_mag;
  assign rem     = a_neg ? (~rem_mag + 1'b1) : rem_mag;

  always_comb begin
    result = is_rem ? rem : quo;
    if (b_zero) begin
      result = is_rem ? a : '1;
    end
  end
endmodule

// File: rtl/execute_div.sv
// Divide/remainder execute stage: pops the issue FIFO head, writes the wb port
// register and broadcasts the renamed result. Purely combinational.
module execute_div
  import execute_div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       issue_div_fifo_data_out,
  input  logic                      issue_div_fifo_data_out_valid,
  output logic                      issue_div_fifo_pop,
  output execute_wb_pack_t          div_wb_port_data_in,
  output logic                      div_wb_port_we,
  output logic                      div_wb_port_flush,
  output execute_feedback_channel_t div_execute_channel_feedback_pack,
  input  commit_feedback_pack_t     commit_feedback_pack
);
  issue_execute_pack_t in_pack;
  logic                cflush;
  logic                go;
  logic                result_ok;
  logic [XLEN-1:0]     div_result;
  logic [XLEN-1:0]     rd_value;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, commit_feedback_pack.committed_rob_id};

  assign in_pack = issue_div_fifo_data_out;
  assign cflush  = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign go      = rst & issue_div_fifo_data_out_valid & ~cflush;

  assign issue_div_fifo_pop = go;
  assign div_wb_port_we     = go;
  assign div_wb_port_flush  = ~go;

  div_core u_div_core (
    .a      (in_pack.src1_value),
    .b      (in_pack.src2_value),
    .div_op (in_pack.sub_op.div_op),
    .result (div_result)
  );

  assign result_ok = in_pack.enable & in_pack.valid & ~in_pack.has_exception;
  assign rd_value  = result_ok ? div_result : '0;

  always_comb begin
    div_wb_port_data_in = '0;
    if (go) begin
      div_wb_port_data_in.enable              = in_pack.enable;
      div_wb_port_data_in.value               = in_pack.value;
      div_wb_port_data_in.valid               = in_pack.valid;
      div_wb_port_data_in.rob_id              = in_pack.rob_id;
      div_wb_port_data_in.pc                  = in_pack.pc;
      div_wb_port_data_in.imm                 = in_pack.imm;
      div_wb_port_data_in.has_exception       = in_pack.has_exception;
      div_wb_port_data_in.exception_id        = in_pack.exception_id;
      div_wb_port_data_in.exception_value     = in_pack.exception_value;
      div_wb_port_data_in.predicted           = in_pack.predicted;
      div_wb_port_data_in.predicted_jump      = in_pack.predicted_jump;
      div_wb_port_data_in.predicted_next_pc   = in_pack.predicted_next_pc;
      div_wb_port_data_in.checkpoint_id_valid = in_pack.checkpoint_id_valid;
      div_wb_port_data_in.checkpoint_id       = in_pack.checkpoint_id;
      div_wb_port_data_in.rs1                 = in_pack.rs1;
      div_wb_port_data_in.arg1_src            = in_pack.arg1_src;
      div_wb_port_data_in.rs1_need_map        = in_pack.rs1_need_map;
      div_wb_port_data_in.rs1_phy             = in_pack.rs1_phy;
      div_wb_port_data_in.src1_value          = in_pack.src1_value;
      div_wb_port_data_in.src1_loaded         = in_pack.src1_loaded;
      div_wb_port_data_in.rs2                 = in_pack.rs2;
      div_wb_port_data_in.arg2_src            = in_pack.arg2_src;
      div_wb_port_data_in.rs2_need_map        = in_pack.rs2_need_map;
      div_wb_port_data_in.rs2_phy             = in_pack.rs2_phy;
      div_wb_port_data_in.src2_value          = in_pack.src2_value;
      div_wb_port_data_in.src2_loaded         = in_pack.src2_loaded;
      div_wb_port_data_in.rd                  = in_pack.rd;
      div_wb_port_data_in.rd_enable           = in_pack.rd_enable;
      div_wb_port_data_in.need_rename         = in_pack.need_rename;
      div_wb_port_data_in.rd_phy              = in_pack.rd_phy;
      div_wb_port_data_in.rd_value            = rd_value;
      div_wb_port_data_in.csr                 = in_pack.csr;
      div_wb_port_data_in.lsu_addr            = in_pack.lsu_addr;
      div_wb_port_data_in.op                  = in_pack.op;
      div_wb_port_data_in.op_unit             = in_pack.op_unit;
      div_wb_port_data_in.sub_op              = in_pack.sub_op;
    end
  end

  always_comb begin
    div_execute_channel_feedback_pack = '0;
    if (go & result_ok & in_pack.rd_enable & in_pack.need_rename) begin
      div_execute_channel_feedback_pack.enable = 1'b1;
      div_execute_channel_feedback_pack.phy_id = in_pack.rd_phy;
      div_execute_channel_feedback_pack.value  = rd_value;
    end
  end
endmodule

// File: tb/tb_execute_div.sv
// Scoreboard bench for execute_div: expectations queued at drive time,
// popped and compared once the combinational outputs have settled.
module tb_execute_div;
  import execute_div_pkg::*;

  logic                      clk;
  logic                      rst;
  issue_execute_pack_t       in_pack;
  logic                      in_valid;
  logic                      pop;
  execute_wb_pack_t          wb_data;
  logic                      wb_we;
  logic                      wb_flush;
  execute_feedback_channel_t fb;
  commit_feedback_pack_t     commit;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    bit          go;
    logic [31:0] rd_value;
    bit          valid;
    bit          has_exc;
    logic [3:0]  exc_id;
    logic [31:0] pc;
    bit          fb_en;
    logic [5:0]  fb_phy;
  } exp_t;

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } corner_t;

  exp_t    sb[$];
  corner_t corners[8];

  execute_div dut (
    .clk                               (clk),
    .rst                               (rst),
    .issue_div_fifo_data_out           (in_pack),
    .issue_div_fifo_data_out_valid     (in_valid),
    .issue_div_fifo_pop                (pop),
    .div_wb_port_data_in               (wb_data),
    .div_wb_port_we                    (wb_we),
    .div_wb_port_flush                 (wb_flush),
    .div_execute_channel_feedback_pack (fb),
    .commit_feedback_pack              (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_div(div_op_t op, logic [31:0] a, logic [31:0] b);
    longint sa;
    longint sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (b == 32'd0) return (op == DIV_DIV || op == DIV_DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      DIV_DIV:  return 32'(sa / sb_);
      DIV_REM:  return 32'(sa % sb_);
      DIV_DIVU: return a / b;
      default:  return a % b;
    endcase
  endfunction

  // Expected outputs for the current stimulus; result is the bench's own value.
  task automatic push_exp(string tag, logic [31:0] result);
    exp_t e;
    bit ok;
    e.tag     = tag;
    e.go      = rst && in_valid && !(commit.enable && commit.flush);
    ok        = in_pack.enable && in_pack.valid && !in_pack.has_exception;
    e.rd_value = ok ? result : 32'd0;
    e.valid   = in_pack.valid;
    e.has_exc = in_pack.has_exception;
    e.exc_id  = in_pack.exception_id;
    e.pc      = in_pack.pc;
    e.fb_en   = e.go && ok && in_pack.rd_enable && in_pack.need_rename;
    e.fb_phy  = in_pack.rd_phy;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, ".pop"},   64'(pop),      64'(e.go));
    check_eq({e.tag, ".we"},    64'(wb_we),    64'(e.go));
    check_eq({e.tag, ".flush"}, 64'(wb_flush), 64'(!e.go));
    if (e.go) begin
      check_eq({e.tag, ".rd_value"}, 64'(wb_data.rd_value),      64'(e.rd_value));
      check_eq({e.tag, ".valid"},    64'(wb_data.valid),         64'(e.valid));
      check_eq({e.tag, ".has_exc"},  64'(wb_data.has_exception), 64'(e.has_exc));
      check_eq({e.tag, ".exc_id"},   64'(wb_data.exception_id),  64'(e.exc_id));
      check_eq({e.tag, ".pc"},       64'(wb_data.pc),            64'(e.pc));
    end else begin
      check_eq({e.tag, ".wb_zero"}, 64'(wb_data == '0), 64'd1);
    end
    check_eq({e.tag, ".fb_en"},  64'(fb.enable), 64'(e.fb_en));
    check_eq({e.tag, ".fb_phy"}, 64'(fb.phy_id), e.fb_en ? 64'(e.fb_phy) : 64'd0);
    check_eq({e.tag, ".fb_val"}, 64'(fb.value),  e.fb_en ? 64'(e.rd_value) : 64'd0);
    $display("txn %s go=%0d pop=%0d rd_value=%08h fb=%0d/%0d/%08h",
             e.tag, e.go, pop, wb_data.rd_value, fb.enable, fb.phy_id, fb.value);
  endtask

  // Drive just after the rising edge, compare on the falling edge.
  task automatic step(string tag, logic [31:0] result);
    push_exp(tag, result);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(div_op_t op, logic [31:0] a, logic [31:0] b, logic [5:0] phy);
    in_pack               = '0;
    in_pack.enable        = 1'b1;
    in_pack.valid         = 1'b1;
    in_pack.rob_id        = 5'($urandom);
    in_pack.pc            = $urandom & 32'hFFFF_FFFC;
    in_pack.rd            = 5'($urandom_range(1, 31));
    in_pack.rd_enable     = 1'b1;
    in_pack.need_rename   = 1'b1;
    in_pack.rd_phy        = phy;
    in_pack.src1_value    = a;
    in_pack.src2_value    = b;
    in_pack.src1_loaded   = 1'b1;
    in_pack.src2_loaded   = 1'b1;
    in_pack.op            = OP_DIV;
    in_pack.op_unit       = UNIT_DIV;
    in_pack.sub_op.div_op = op;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    corners[0] = '{DIV_DIV,  32'd7,          32'd0,          32'hFFFF_FFFF};
    corners[1] = '{DIV_REM,  32'd7,          32'd0,          32'd7};
    corners[2] = '{DIV_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    corners[3] = '{DIV_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    corners[4] = '{DIV_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    corners[5] = '{DIV_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    corners[6] = '{DIV_DIVU, 32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF};
    corners[7] = '{DIV_REMU, 32'd10,         32'd3,          32'd1};

    rst      = 1'b0;
    commit   = '0;
    set_div(DIV_DIV, 32'd9, 32'd3, 6'd4);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    step("reset_hold", 32'd3);

    rst      = 1'b1;
    in_valid = 1'b0;
    step("idle", 32'd0);

    in_pack               = '0;
    in_pack.enable        = 1'b1;
    in_pack.has_exception = 1'b1;
    in_pack.exception_id  = EXC_ILLEGAL_INSTRUCTION;
    in_pack.rd_enable     = 1'b1;
    in_pack.need_rename   = 1'b1;
    in_pack.rd_phy        = 6'd7;
    in_pack.pc            = 32'h0000_1000;
    step("exc_empty", 32'd0);
    in_valid = 1'b1;
    step("exc_illegal", 32'd0);

    in_pack.valid        = 1'b1;
    in_pack.exception_id = EXC_BREAKPOINT;
    in_pack.src1_value   = 32'd20;
    in_pack.src2_value   = 32'd5;
    step("exc_breakpoint", 32'd0);

    set_div(DIV_DIV, 32'd12, 32'd6, 6'd10);
    step("div_12_6", 32'd2);
    commit.enable = 1'b1;
    step("div_commit_noflush", 32'd2);
    commit.flush = 1'b1;
    step("div_commit_flush", 32'd2);
    commit = '0;

    foreach (corners[i]) begin
      set_div(corners[i].op, corners[i].a, corners[i].b, 6'(i + 1));
      step($sformatf("corner%0d", i), corners[i].r);
    end

    for (int i = 0; i < 40; i++) begin
      div_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      op = div_op_t'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom >> $urandom_range(0, 28);
      set_div(op, a, b, 6'($urandom));
      in_pack.need_rename = ($urandom_range(0, 5) != 0);
      in_valid            = ($urandom_range(0, 7) != 0);
      step($sformatf("rand%0d", i), ref_div(op, a, b));
    end

    set_div(DIV_DIVU, 32'd100, 32'd7, 6'd33);
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    push_exp("async_reset", 32'd14);
    #1;
    compare_front();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/execute_div.md
Name: execute_div

Overview:
- Single-issue RISC-V M-extension divide/remainder execute unit.
- Takes one instruction from the issue→div FIFO head and computes the quotient or remainder (XLEN=32) combinationally.
- Writes the result into the div→writeback port register and broadcasts the renamed destination value on its execute feedback channel for wakeup/bypass.
- Honours pipeline flushes from commit.

Parameters:
- None local. Widths come from the shared config package: XLEN=32, PHY_REG_ID_WIDTH, ROB_ID_WIDTH, CHECKPOINT_ID_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- issue_div_fifo_data_out  input  issue_execute_pack_t  instruction at FIFO head.
- issue_div_fifo_data_out_valid  input  1  FIFO head valid (non-empty).
- issue_div_fifo_pop  output  1  consume FIFO head this cycle.
- div_wb_port_data_in  output  execute_wb_pack_t  data written to the wb port register.
- div_wb_port_we  output  1  wb port write enable.
- div_wb_port_flush  output  1  clear wb port register (to empty/enable=0).
- div_execute_channel_feedback_pack  output  execute_feedback_channel_t  {enable, phy_id, value} result broadcast.
- commit_feedback_pack  input  commit_feedback_pack_t  commit status; uses enable and flush.

Behaviour:
- All outputs are combinational from the inputs; there is no internal state. clk is unused except for lint, and rst acts only as an output gate.
- Definitions:
  - cflush = commit_feedback_pack.enable & commit_feedback_pack.flush.
  - go = rst_n_high & issue_div_fifo_data_out_valid & ~cflush, where rst_n_high means rst==1.
- Port control:
  - issue_div_fifo_pop = go.
  - div_wb_port_we = go.
  - div_wb_port_flush = ~go.
  - An idle cycle (FIFO empty), a commit flush, or reset writes an empty bubble into the wb port.
- While rst is asserted (rst=0): pop=0, we=0, flush=1, div_wb_port_data_in all zero, feedback.enable=0, phy_id=0, value=0.
- div_wb_port_data_in when go:
  - Copy every shared field of the input pack: enable, value, valid, rob_id, pc, imm, has_exception, exception_id, exception_value, predicted, predicted_jump, predicted_next_pc, checkpoint_id_valid, checkpoint_id, rs1, arg1_src, rs1_need_map, rs1_phy, src1_value, src1_loaded, rs2/arg2/rs2 fields, rd, rd_enable, need_rename, rd_phy, csr, lsu_addr, op, op_unit, sub_op.
  - rd_value = result if (enable & valid & ~has_exception), else 0.
- div_wb_port_data_in when ~go: all zero.
- Result, with a = src1_value and b = src2_value, selected by sub_op.div_op:
  - div: signed a/b, truncating toward zero.
  - divu: unsigned a/b.
  - rem: signed remainder; sign follows a.
  - remu: unsigned remainder.
- Divide-by-zero (b==0):
  - div/divu return 0xFFFFFFFF.
  - rem/remu return a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF):
  - div returns 0x80000000.
  - rem returns 0.
- Feedback channel:
  - enable = go & enable & valid & ~has_exception & rd_enable & need_rename.
  - phy_id = rd_phy and value = rd_value when enabled; both 0 otherwise.
- Exception pass-through:
  - An instruction with has_exception=1 is still popped and written (we=1), with rd_value=0 and feedback disabled.
  - The valid flag is passed through unchanged.
- Simultaneous FIFO valid and commit flush: the flush wins (pop=0, we=0, flush=1). The instruction is not consumed; upstream flushes the FIFO.

Decomposition:
- Shared package (common): issue_execute_pack_t, execute_wb_pack_t, execute_feedback_channel_t, commit_feedback_pack_t, op_t, op_unit_t, div_op_t {div, divu, rem, remu}, riscv_exception_t, arg_src_t.
- Shared config: XLEN and ID widths.
- One natural sub-module: div_core. It is a combinational 32-bit signed/unsigned divider with the RISC-V special cases, with inputs (a, b, div_op) and output result.

Test Plan:
- Reset then release, FIFO empty → we=0, flush=1, pop=0, wb data.enable=0, feedback.enable=0.
- FIFO head enable=1, has_exception=1 (illegal_instruction), valid_in FIFO=0 → we=0, flush=1, pop=0. Set FIFO valid=1 → we=1, flush=0, pop=1, data.has_exception=1, exception_id=illegal_instruction, data.valid=0, feedback.enable=0.
- valid=1, has_exception=1 (breakpoint) → we=1, pop=1, data.valid=1, exception_id=breakpoint, feedback.enable=0.
- div 12/6, rd_enable=1, need_rename=1, rd_phy=10 → rd_value=2, feedback {1, 10, 2}. Repeat with commit enable=1, flush=0 → unchanged. Then flush=1 → we=0, flush=1, pop=0, feedback.enable=0.
- Corner values:
  - div 7/0 → 0xFFFFFFFF.
  - rem 7/0 → 7.
  - div 0x80000000/-1 → 0x80000000.
  - rem 0x80000000/-1 → 0.
  - div -7/2 → -3.
  - rem -7/2 → -1.
  - divu 0xFFFFFFFE/2 → 0x7FFFFFFF.
  - remu 10/3 → 1.
- Assert rst=0 mid-stream with FIFO valid → pop=0, we=0, flush=1, feedback.enable=0 immediately (asynchronously).
